// File: rtl/bram_pkg.sv
// Shared types and default geometry for the dual-port BRAM.
package bram_pkg;

    typedef enum logic {
        WRITE_FIRST,
        READ_FIRST
    } write_mode_e;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/tdp_bram_64kx8_if.sv
// Signal bundle for both BRAM ports: A is the TRS-80 bus side, B the ESP SPI side.
interface tdp_bram_64kx8_if
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  ena;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  regcea;
    logic [DATA_WIDTH-1:0] douta;

    logic                  enb;
    logic                  web;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dinb;
    logic                  regceb;
    logic [DATA_WIDTH-1:0] doutb;

    modport master (
        output ena, wea, addra, dina, regcea,
        input  douta,
        output enb, web, addrb, dinb, regceb,
        input  doutb
    );

    modport slave (
        input  ena, wea, addra, dina, regcea,
        output douta,
        input  enb, web, addrb, dinb, regceb,
        output doutb
    );

endinterface

// File: rtl/bram_port_pipe.sv
// Read latch plus output register for one BRAM port; WRITE_MODE picks what a write latches.
module bram_port_pipe
    import bram_pkg::*;
#(
    parameter write_mode_e WRITE_MODE = WRITE_FIRST,
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] rd_word,
    input  logic                  regce,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] latch_q = '0;
    logic [DATA_WIDTH-1:0] latch_d;
    logic [DATA_WIDTH-1:0] dout_q = '0;
    logic [DATA_WIDTH-1:0] dout_d;

    // A read-first port never looks at its write data here.
    logic unused_wr_inputs;
    assign unused_wr_inputs = ^{we, din};

    always_comb begin
        latch_d = latch_q;
        dout_d  = dout_q;
        if (en) begin
            latch_d = (WRITE_MODE == WRITE_FIRST && we) ? din : rd_word;
        end
        if (regce) begin
            dout_d = latch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q <= '0;
            dout_q  <= '0;
        end else begin
            latch_q <= latch_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/tdp_bram_64kx8.sv
// True dual-port 64K x 8 block RAM on one clock, 2-cycle read latency per port.
module tdp_bram_64kx8
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    tdp_bram_64kx8_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic                  wr_a;
    logic                  wr_b;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    // Both ports read the pre-edge contents, so cross-port reads always see old data.
    always_comb begin
        wr_a = bus.ena & bus.wea;
        wr_b = bus.enb & bus.web;
        rd_a = mem_q[bus.addra];
        rd_b = mem_q[bus.addrb];
    end

    // Port B is written last so it wins a same-address double write.
    always_ff @(posedge clk) begin
        if (wr_a) begin
            mem_q[bus.addra] <= bus.dina;
        end
        if (wr_b) begin
            mem_q[bus.addrb] <= bus.dinb;
        end
    end

    bram_port_pipe #(
        .WRITE_MODE (WRITE_FIRST),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe_a (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.ena),
        .we      (bus.wea),
        .din     (bus.dina),
        .rd_word (rd_a),
        .regce   (bus.regcea),
        .dout    (bus.douta)
    );

    bram_port_pipe #(
        .WRITE_MODE (READ_FIRST),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe_b (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.enb),
        .we      (bus.web),
        .din     (bus.dinb),
        .rd_word (rd_b),
        .regce   (bus.regceb),
        .dout    (bus.doutb)
    );

endmodule

// File: tb/tb_tdp_bram_64kx8.sv
// Bench for tdp_bram_64kx8: directed pokes/peeks and collisions, then random dual-port traffic.
module tb_tdp_bram_64kx8;
    import bram_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam logic [AW-1:0] WIN_BASE = 16'h4000;

    logic clk = 1'b0;
    logic reset;

    tdp_bram_64kx8_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    tdp_bram_64kx8 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    logic [DW-1:0] model_mem [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_inputs();
        bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = '0; bus.dina = '0; bus.regcea = 1'b0;
        bus.enb = 1'b0; bus.web = 1'b0; bus.addrb = '0; bus.dinb = '0; bus.regceb = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = a; bus.dina = d;
        tick();
        bus.ena = 1'b0; bus.wea = 1'b0;
    endtask

    task automatic write_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = a; bus.dinb = d;
        tick();
        bus.enb = 1'b0; bus.web = 1'b0;
    endtask

    task automatic read_a(input logic [AW-1:0] a, output logic [DW-1:0] d);
        bus.ena = 1'b1; bus.wea = 1'b0; bus.addra = a;
        tick();
        bus.ena = 1'b0; bus.regcea = 1'b1;
        tick();
        bus.regcea = 1'b0;
        d = bus.douta;
    endtask

    task automatic read_b(input logic [AW-1:0] a, output logic [DW-1:0] d);
        bus.enb = 1'b1; bus.web = 1'b0; bus.addrb = a;
        tick();
        bus.enb = 1'b0; bus.regceb = 1'b1;
        tick();
        bus.regceb = 1'b0;
        d = bus.doutb;
    endtask

    // Fire both output registers one cycle after a dual-port access.
    task automatic capture_both();
        bus.ena = 1'b0; bus.wea = 1'b0; bus.enb = 1'b0; bus.web = 1'b0;
        bus.regcea = 1'b1; bus.regceb = 1'b1;
        tick();
        bus.regcea = 1'b0; bus.regceb = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] last_a;
        logic [DW-1:0] last_b;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        int ia;
        int ib;

        idle_inputs();
        do_reset(2);
        check_eq("reset_douta", bus.douta, 8'h00);
        check_eq("reset_doutb", bus.doutb, 8'h00);
        read_a(16'h0000, rd);
        check_eq("init_read_a", rd, 8'h00);
        read_b(16'hFFFF, rd);
        check_eq("init_read_b", rd, 8'h00);
        read_a(16'h9000 + 16'($urandom_range(0, 255)), rd);
        check_eq("init_read_a_rand", rd, 8'h00);

        // Port B poke then peek with the latency checked on both sides of the capture edge.
        write_b(16'h1234, 8'h5A);
        bus.enb = 1'b1; bus.addrb = 16'h1234;
        tick();
        bus.enb = 1'b0; bus.regceb = 1'b1;
        check_eq("b_latency_early", bus.doutb, 8'h00);
        tick();
        bus.regceb = 1'b0;
        check_eq("b_peek", bus.doutb, 8'h5A);

        write_a(16'h8000, 8'hC3);
        bus.regcea = 1'b1;
        tick();
        bus.regcea = 1'b0;
        check_eq("a_write_first", bus.douta, 8'hC3);
        read_b(16'h8000, rd);
        check_eq("b_reads_a_write", rd, 8'hC3);

        write_b(16'h0010, 8'h11);
        bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = 16'h0010; bus.dinb = 8'h22;
        tick();
        bus.enb = 1'b0; bus.web = 1'b0; bus.regceb = 1'b1;
        tick();
        bus.regceb = 1'b0;
        check_eq("b_read_first", bus.doutb, 8'h11);
        read_b(16'h0010, rd);
        check_eq("b_after_write", rd, 8'h22);

        // Same-address collisions at 0x00FF.
        write_b(16'h00FF, 8'h33);
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 16'h00FF; bus.dina = 8'hAA;
        bus.enb = 1'b1; bus.web = 1'b0; bus.addrb = 16'h00FF;
        tick();
        capture_both();
        check_eq("coll_awr_douta", bus.douta, 8'hAA);
        check_eq("coll_awr_doutb_old", bus.doutb, 8'h33);
        read_b(16'h00FF, rd);
        check_eq("coll_awr_mem", rd, 8'hAA);

        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 16'h00FF; bus.dina = 8'hAA;
        bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = 16'h00FF; bus.dinb = 8'hBB;
        tick();
        capture_both();
        check_eq("coll_both_douta", bus.douta, 8'hAA);
        check_eq("coll_both_doutb_old", bus.doutb, 8'hAA);
        read_a(16'h00FF, rd);
        check_eq("coll_both_mem_b_wins", rd, 8'hBB);

        bus.ena = 1'b1; bus.wea = 1'b0; bus.addra = 16'h00FF;
        bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = 16'h00FF; bus.dinb = 8'h44;
        tick();
        capture_both();
        check_eq("coll_bwr_douta_old", bus.douta, 8'hBB);
        check_eq("coll_bwr_doutb_old", bus.doutb, 8'hBB);
        read_b(16'h00FF, rd);
        check_eq("coll_bwr_mem", rd, 8'h44);

        // Output register hold, then reset overriding regce.
        read_a(16'h1234, rd);
        check_eq("a_peek_5a", rd, 8'h5A);
        bus.ena = 1'b1; bus.wea = 1'b0; bus.addra = 16'h8000; bus.regcea = 1'b0;
        tick();
        bus.ena = 1'b0;
        tick();
        check_eq("a_regce_hold", bus.douta, 8'h5A);
        reset = 1'b1; bus.regcea = 1'b1; bus.ena = 1'b1; bus.addra = 16'h8000;
        bus.regceb = 1'b1;
        tick();
        reset = 1'b0; bus.ena = 1'b0;
        check_eq("reset_prio_douta", bus.douta, 8'h00);
        check_eq("reset_prio_doutb", bus.doutb, 8'h00);
        tick();
        bus.regcea = 1'b0; bus.regceb = 1'b0;
        check_eq("reset_clears_latch_a", bus.douta, 8'h00);
        check_eq("reset_clears_latch_b", bus.doutb, 8'h00);
        read_a(16'h1234, rd);
        check_eq("mem_survives_reset", rd, 8'h5A);

        // Random dual-port traffic over a small untouched window to force collisions.
        idle_inputs();
        do_reset(1);
        for (int i = 0; i < 4; i++) model_mem[i] = '0;
        last_a = '0;
        last_b = '0;
        exp_a_q.push_back(8'h00);
        exp_b_q.push_back(8'h00);
        bus.regcea = 1'b1;
        bus.regceb = 1'b1;
        for (int n = 0; n < 400; n++) begin
            ia = int'($urandom_range(0, 3));
            ib = int'($urandom_range(0, 3));
            bus.ena = ($urandom_range(0, 3) != 0);
            bus.wea = 1'($urandom_range(0, 1));
            bus.addra = WIN_BASE + 16'(ia);
            bus.dina = 8'($urandom);
            bus.enb = ($urandom_range(0, 3) != 0);
            bus.web = 1'($urandom_range(0, 1));
            bus.addrb = WIN_BASE + 16'(ib);
            bus.dinb = 8'($urandom);

            ea = last_a;
            if (bus.ena) ea = bus.wea ? bus.dina : model_mem[ia];
            eb = bus.enb ? model_mem[ib] : last_b;
            if (bus.ena && bus.wea) model_mem[ia] = bus.dina;
            if (bus.enb && bus.web) model_mem[ib] = bus.dinb;
            last_a = ea;
            last_b = eb;
            exp_a_q.push_back(ea);
            exp_b_q.push_back(eb);

            tick();
            check_eq("rand_douta", bus.douta, exp_a_q.pop_front());
            check_eq("rand_doutb", bus.doutb, exp_b_q.pop_front());
        end
        bus.ena = 1'b0; bus.wea = 1'b0; bus.enb = 1'b0; bus.web = 1'b0;
        tick();
        check_eq("rand_flush_douta", bus.douta, exp_a_q.pop_front());
        check_eq("rand_flush_doutb", bus.doutb, exp_b_q.pop_front());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
